// File: rtl/alu_cmd_ctrl_if.sv
// Command / external-ALU / response bundle for alu_cmd_ctrl.
// The controller takes the slave modport; the command source, ALU and consumer take master.
interface alu_cmd_ctrl_if #(
  parameter int COUNT_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [3:0]         cmd_a;
  logic [3:0]         cmd_b;
  logic               cmd_acc;

  logic [3:0]         alu_a;
  logic [3:0]         alu_b;
  logic [1:0]         alu_select;
  logic [3:0]         alu_result;
  logic               alu_carry;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [3:0]         rsp_data;
  logic               rsp_carry;
  logic [COUNT_W-1:0] op_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
    input  alu_result, alu_carry,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_select,
    output rsp_valid, rsp_data, rsp_carry, op_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_acc,
    output alu_result, alu_carry,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_select,
    input  rsp_valid, rsp_data, rsp_carry, op_count
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Three-state controller that registers a command onto an external ALU and captures its result.
// Define ALU_CMD_CTRL_ACC_EN to let cmd_acc feed the previous rsp_data back as operand A.
module alu_cmd_ctrl #(
  parameter int COUNT_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_cmd_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b11;

  logic [1:0]         state_q,      state_d;
  logic [3:0]         alu_a_q,      alu_a_d;
  logic [3:0]         alu_b_q,      alu_b_d;
  logic [1:0]         alu_select_q, alu_select_d;
  logic [3:0]         rsp_data_q,   rsp_data_d;
  logic               rsp_carry_q,  rsp_carry_d;
  logic               rsp_valid_q,  rsp_valid_d;
  logic [COUNT_W-1:0] op_count_q,   op_count_d;

  logic [3:0]         a_src;

`ifdef ALU_CMD_CTRL_ACC_EN
  assign a_src = bus.cmd_acc ? rsp_data_q : bus.cmd_a;
`else
  logic unused_cmd_acc;
  assign unused_cmd_acc = bus.cmd_acc;
  assign a_src          = bus.cmd_a;
`endif

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_select_d = alu_select_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_valid_d  = rsp_valid_q;
    op_count_d   = op_count_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_a_d      = a_src;
          alu_b_d      = bus.cmd_b;
          alu_select_d = bus.cmd_op;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Operands have been stable on the ALU for a full cycle; capture its output.
        rsp_data_d  = bus.alu_result;
        rsp_carry_d = (alu_select_q == OP_ADD) ? bus.alu_carry : 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_select_q <= '0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_select_q <= alu_select_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_valid_q  <= rsp_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_select = alu_select_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl: vector table through a scoreboard, plus reset corner cases.
// Build with or without ALU_CMD_CTRL_ACC_EN; the accumulate expectation follows the macro.
module tb_alu_cmd_ctrl;
  localparam int CW = 2;

  logic clk;
  logic reset;

  alu_cmd_ctrl_if #(.COUNT_W(CW)) bus ();

  alu_cmd_ctrl #(.COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: carry-out is always the adder carry so the controller must mask it.
  logic [4:0] alu_sum;
  assign alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign bus.alu_carry = alu_sum[4];
  always_comb begin
    case (bus.alu_select)
      2'b00:   bus.alu_result = bus.alu_a & bus.alu_b;
      2'b01:   bus.alu_result = bus.alu_a | bus.alu_b;
      2'b10:   bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: bus.alu_result = alu_sum[3:0];
    endcase
  end

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       acc;
    int         hold;
    logic [3:0] d;
    logic       c;
  } vec_t;

  typedef struct packed {
    logic [3:0] d;
    logic       c;
  } exp_t;

  vec_t      vecs[8];
  exp_t      sb[$];
  int        checks = 0;
  int        errors = 0;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    exp_t e;
    @(negedge clk);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_a     = v.a;
    bus.cmd_b     = v.b;
    bus.cmd_acc   = v.acc;
    sb.push_back('{d: v.d, c: v.c});
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 4'h5;
    bus.cmd_b     = 4'h5;
    chk("issue_rsp_valid", bus.rsp_valid, 0);
    chk("issue_cmd_ready", bus.cmd_ready, 0);
    chk("issue_alu_b", bus.alu_b, v.b);
    chk("issue_alu_select", bus.alu_select, v.op);
    bus.rsp_ready = (v.hold == 0);
    @(posedge clk);
    @(negedge clk);
    chk("resp_rsp_valid", bus.rsp_valid, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk("resp_data", bus.rsp_data, e.d);
    chk("resp_carry", bus.rsp_carry, e.c);
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_data", bus.rsp_data, e.d);
      chk("hold_carry", bus.rsp_carry, e.c);
      chk("hold_cmd_ready", bus.cmd_ready, 0);
      chk("hold_op_count", bus.op_count, exp_cnt);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    chk("done_rsp_valid", bus.rsp_valid, 0);
    chk("done_cmd_ready", bus.cmd_ready, 1);
    chk("done_op_count", bus.op_count, exp_cnt);
    chk("done_data_kept", bus.rsp_data, e.d);
    $display("op=%0d a=%0h b=%0h acc=%0b -> data=%0h carry=%0b count=%0d",
             v.op, v.a, v.b, v.acc, bus.rsp_data, bus.rsp_carry, bus.op_count);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 0);
    chk({tag, "_rsp_carry"}, bus.rsp_carry, 0);
    chk({tag, "_op_count"}, bus.op_count, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_select"}, bus.alu_select, 0);
  endtask

  initial begin
    vecs[0] = '{2'b11, 4'hF, 4'h1, 1'b0, 0, 4'h0, 1'b1};
    vecs[1] = '{2'b00, 4'hC, 4'hA, 1'b0, 0, 4'h8, 1'b0};
    vecs[2] = '{2'b01, 4'hC, 4'hA, 1'b0, 0, 4'hE, 1'b0};
    vecs[3] = '{2'b10, 4'hC, 4'hA, 1'b0, 0, 4'h6, 1'b0};
    vecs[4] = '{2'b11, 4'hC, 4'hA, 1'b0, 5, 4'h6, 1'b1};
    vecs[5] = '{2'b11, 4'h3, 4'h4, 1'b0, 0, 4'h7, 1'b0};
`ifdef ALU_CMD_CTRL_ACC_EN
    vecs[6] = '{2'b11, 4'h0, 4'h2, 1'b1, 0, 4'h9, 1'b0};
`else
    vecs[6] = '{2'b11, 4'h0, 4'h2, 1'b1, 0, 4'h2, 1'b0};
`endif
    vecs[7] = '{2'b10, 4'h9, 4'h9, 1'b0, 2, 4'h0, 1'b0};

    exp_cnt       = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    bus.cmd_acc   = 1'b0;
    bus.rsp_ready = 1'b0;
    reset         = 1'b1;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

    // Reset while in ISSUE: operation dropped, back to IDLE with cleared registers.
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b11;
    bus.cmd_a     = 4'h7;
    bus.cmd_b     = 4'h7;
    @(posedge clk);
    #2;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    #1;
    exp_cnt = '0;
    chk_all_zero("rst_issue");
    @(negedge clk);
    reset = 1'b0;
    $display("reset in ISSUE -> cmd_ready=%0b count=%0d", bus.cmd_ready, bus.op_count);

    // Reset while the response is waiting on rsp_ready.
    run_cmd(vecs[0]);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_a     = 4'h3;
    bus.cmd_b     = 4'hC;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_rsp_valid", bus.rsp_valid, 1);
    chk("pre_rst_data", bus.rsp_data, 4'hF);
    #2;
    reset = 1'b1;
    #1;
    exp_cnt = '0;
    chk_all_zero("rst_resp");
    @(negedge clk);
    reset = 1'b0;
    $display("reset in RESP -> rsp_valid=%0b count=%0d", bus.rsp_valid, bus.op_count);

    run_cmd(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
